hash_rx: RTL and testbench
==========================

# hash_rx

Serial front end of the MD5 cracker. Receives the 16-byte target digest over RS-232 (8N1, raw binary, most significant byte first). Assembles the bytes into a 128-bit word and presents it to the comparator and search counter as `md5in`/`md5valid`. Sits between the `rs232rx` pin and the compare/counter stages; `md5valid` directly gates whether the search runs.

## Interface

Parameters:
- `CLKS_PER_BIT`, 434: clock cycles per UART bit (50 MHz / 115200). Must be ≥ 8.
- `TIMEOUT_CLKS`, 50000: idle cycles between bytes after which a partial digest is discarded.

Ports:
- `clk`  in  1  system clock; everything is on its rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `rs232rx`  in  1  raw asynchronous serial line; idles high.
- `md5in`  out  128  target digest; byte 0 received is `[127:120]`, byte 15 is `[7:0]`.
- `md5valid`  out  1  level: `md5in` holds a complete digest.
- `frame_err`  out  1  one-cycle pulse on a stop-bit error.

## Operation

- **Input synchronizer:** `rs232rx` passes through a 2-flop synchronizer (both flops reset to 1). All decisions use the synchronized value `rxs`.
- **Bit FSM states:** IDLE, START, DATA, STOP, WAITHI.
  - IDLE → START when `rxs`=0.
  - START: at `CLKS_PER_BIT/2` (integer division), sample `rxs`. If 0 → DATA. If 1 → IDLE as a glitch; no error and no byte.
  - DATA: sample 8 bits LSB first, each `CLKS_PER_BIT` after the previous sample → STOP.
  - STOP: sample `CLKS_PER_BIT` after bit 7.
    - If 1: the byte is accepted → IDLE.
    - If 0: `frame_err` pulses, the byte is dropped, the partial digest is discarded → WAITHI.
  - WAITHI → IDLE once `rxs`=1.
- **Assembler:**
  - Holds a 4-bit byte count `cnt` (0..15) and a 120-bit shift register.
  - When a byte is accepted with `cnt`=0: `md5valid` drops to 0 that cycle. `md5in` keeps its old value. This pauses the search while a new target loads.
  - When a byte is accepted with `cnt`<15: it shifts in and `cnt` increments.
  - When a byte is accepted with `cnt`=15: `md5in` is loaded as {shift[119:0], byte} and `md5valid` goes to 1. `cnt` wraps to 0. `md5in` changes only here and on reset.
- **Timeout:**
  - The timer runs only when the FSM is in IDLE and `cnt`≠0. It clears on every accepted byte.
  - On reaching `TIMEOUT_CLKS`, `cnt` goes to 0 and the partial digest is discarded. `md5valid` stays 0.
  - A byte accept and a timeout cannot coincide, because the timer does not run outside IDLE.
- **Frame error** with `cnt`≠0: `cnt` goes to 0 and `md5valid` stays 0.
- **Frame error** with `cnt`=0: `cnt` stays 0 and `md5valid` and `md5in` are unchanged. A framing error on the first byte does not disturb a loaded target.

## Timing

- **Reset values:** `md5in`=0, `md5valid`=0, `frame_err`=0, FSM in IDLE, `cnt`=0, timer=0, synchronizer flops=1.
- **Reset mid-frame:** applies the reset values on the next edge. Any partial byte or digest is lost.
- **Sample points:** t0 is the first cycle `rxs`=0 (2 cycles after the pin falls).
  - Start check: t0+`CLKS_PER_BIT/2`.
  - Data bit i: t0+`CLKS_PER_BIT/2`+(i+1)·`CLKS_PER_BIT`.
  - Stop bit: t0+`CLKS_PER_BIT/2`+9·`CLKS_PER_BIT`.
- **Output timing:**
  - `md5valid` rises and `md5in` updates on the edge after the 16th stop sample.
  - `md5valid` falls on the edge after the first byte's stop sample.
  - `frame_err` is high for exactly the cycle after a failing stop sample.
- **Back-to-back frames:** the next start bit may begin immediately after the stop-sample cycle. The FSM re-arms in IDLE and does not wait for the end of the stop bit.

## Structure

- **Shared package** `fpga_md5_pkg`:
  - `MD5_BITS`=128 and `HASH_BYTES`=16.
  - A `uart_state_t` enum (IDLE, START, DATA, STOP, WAITHI).
- **Sub-module** `uart_rx_byte`, parameterized by `CLKS_PER_BIT`:
  - Contains the synchronizer, the bit FSM and the bit timer.
  - Outputs: `byte[7:0]`, a one-cycle `byte_stb`, and a one-cycle `ferr`.
  - `hash_rx` instantiates it and holds the assembler and timeout logic.

## Test plan

All scenarios use `CLKS_PER_BIT`=16 and `TIMEOUT_CLKS`=400.

- **Reset:** hold `rst` 3 cycles with line idle → `md5in`=0, `md5valid`=0, `frame_err`=0.
- **Full digest:** send bytes d4 1d 8c d9 8f 00 b2 04 e9 80 09 98 ec f8 42 7e → one cycle after the last stop sample, `md5in`=128'hd41d8cd98f00b204e9800998ecf8427e and `md5valid`=1. `md5valid` was 0 before that.
- **Reload:** with a digest loaded, send byte 0x11 → `md5valid`=0 and `md5in` unchanged. After 15 more bytes 0x22..0x30, the new value is loaded and `md5valid`=1.
- **Timeout:** send 5 bytes, stay idle 400 cycles, then send a full 16-byte digest → `md5in` equals exactly those 16 bytes.
- **Framing:**
  - Byte 3 with stop bit 0 → `frame_err` pulses 1 cycle and the count resets. A following full digest loads correctly.
  - A 4-cycle low glitch on the line → no byte, no `frame_err`.
- **Reset mid-byte:** assert `rst` during DATA of byte 7 → reset values. A following full digest loads correctly.

Source files
------------

// File: rtl/fpga_md5_pkg.sv
// rtl/fpga_md5_pkg.sv - shared sizes and UART receiver state encoding for the MD5 cracker
package fpga_md5_pkg;

  localparam int MD5_BITS   = 128;
  localparam int HASH_BYTES = 16;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAITHI
  } uart_state_t;

endpackage

// File: rtl/uart_rx_byte.sv
// rtl/uart_rx_byte.sv - 8N1 byte receiver: input synchronizer, bit FSM and bit timer
module uart_rx_byte
  import fpga_md5_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rs232rx,
  output logic [7:0] rx_byte,
  output logic       byte_stb,
  output logic       ferr,
  output logic       idle
);

  localparam int TW = $clog2(CLKS_PER_BIT);
  localparam logic [TW-1:0] HALF_LAST = TW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [TW-1:0] BIT_LAST  = TW'(CLKS_PER_BIT - 1);

  logic          sync1_q, sync2_q;
  uart_state_t   state_q, state_d;
  logic [TW-1:0] tmr_q, tmr_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shreg_q, shreg_d;
  logic          rxs;

  assign rxs = sync2_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      state_q <= IDLE;
      tmr_q   <= '0;
      bit_q   <= '0;
      shreg_q <= '0;
    end else begin
      sync1_q <= rs232rx;
      sync2_q <= sync1_q;
      state_q <= state_d;
      tmr_q   <= tmr_d;
      bit_q   <= bit_d;
      shreg_q <= shreg_d;
    end
  end

  // Timer restarts at 0 on every state entry, so each compare lands exactly on its sample cycle.
  always_comb begin
    state_d  = state_q;
    tmr_d    = tmr_q + 1'b1;
    bit_d    = bit_q;
    shreg_d  = shreg_q;
    byte_stb = 1'b0;
    ferr     = 1'b0;
    unique case (state_q)
      IDLE: begin
        tmr_d = '0;
        bit_d = '0;
        if (!rxs) state_d = START;
      end
      START: begin
        if (tmr_q == HALF_LAST) begin
          tmr_d   = '0;
          state_d = rxs ? IDLE : DATA;
        end
      end
      DATA: begin
        if (tmr_q == BIT_LAST) begin
          tmr_d   = '0;
          shreg_d = {rxs, shreg_q[7:1]};
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) state_d = STOP;
        end
      end
      STOP: begin
        if (tmr_q == BIT_LAST) begin
          tmr_d = '0;
          if (rxs) begin
            byte_stb = 1'b1;
            state_d  = IDLE;
          end else begin
            ferr    = 1'b1;
            state_d = WAITHI;
          end
        end
      end
      WAITHI: begin
        tmr_d = '0;
        if (rxs) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign rx_byte = shreg_q;
  assign idle    = (state_q == IDLE);

endmodule

// File: rtl/hash_rx.sv
// rtl/hash_rx.sv - assembles 16 serial bytes into the target digest, with inter-byte timeout
module hash_rx
  import fpga_md5_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434,
  parameter int TIMEOUT_CLKS = 50000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                rs232rx,
  output logic [MD5_BITS-1:0] md5in,
  output logic                md5valid,
  output logic                frame_err
);

  localparam int TOW = $clog2(TIMEOUT_CLKS);
  localparam logic [TOW-1:0] TO_LAST  = TOW'(TIMEOUT_CLKS - 1);
  localparam logic [3:0]     CNT_LAST = 4'(HASH_BYTES - 1);

  logic [7:0]          rx_byte;
  logic                byte_stb, ferr, idle;

  logic [3:0]          cnt_q, cnt_d;
  logic [MD5_BITS-9:0] shift_q, shift_d;
  logic [MD5_BITS-1:0] md5_q, md5_d;
  logic                valid_q, valid_d;
  logic                ferr_q;
  logic [TOW-1:0]      tmr_q, tmr_d;

  uart_rx_byte #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_rx (
    .clk     (clk),
    .rst     (rst),
    .rs232rx (rs232rx),
    .rx_byte (rx_byte),
    .byte_stb(byte_stb),
    .ferr    (ferr),
    .idle    (idle)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q   <= '0;
      shift_q <= '0;
      md5_q   <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      tmr_q   <= '0;
    end else begin
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
      md5_q   <= md5_d;
      valid_q <= valid_d;
      ferr_q  <= ferr;
      tmr_q   <= tmr_d;
    end
  end

  // The first byte of a new target drops valid to pause the search; md5in only moves on the 16th.
  always_comb begin
    cnt_d   = cnt_q;
    shift_d = shift_q;
    md5_d   = md5_q;
    valid_d = valid_q;
    tmr_d   = tmr_q;
    if (byte_stb) begin
      tmr_d = '0;
      if (cnt_q == CNT_LAST) begin
        md5_d   = {shift_q, rx_byte};
        valid_d = 1'b1;
        cnt_d   = '0;
      end else begin
        shift_d = {shift_q[MD5_BITS-17:0], rx_byte};
        cnt_d   = cnt_q + 4'd1;
        if (cnt_q == 4'd0) valid_d = 1'b0;
      end
    end else if (ferr) begin
      tmr_d = '0;
      cnt_d = '0;
    end else if (idle && cnt_q != 4'd0) begin
      if (tmr_q == TO_LAST) begin
        tmr_d = '0;
        cnt_d = '0;
      end else begin
        tmr_d = tmr_q + 1'b1;
      end
    end
  end

  assign md5in     = md5_q;
  assign md5valid  = valid_q;
  assign frame_err = ferr_q;

endmodule

// File: tb/tb_hash_rx.sv
// tb/tb_hash_rx.sv - directed self-checking bench for hash_rx
module tb_hash_rx;

  localparam int CPB = 16;
  localparam int TO  = 400;

  localparam logic [127:0] D1 = 128'hd41d8cd98f00b204e9800998ecf8427e;
  localparam logic [127:0] D2 = 128'h1122232425262728292a2b2c2d2e2f30;
  localparam logic [127:0] D3 = 128'h0f1e2d3c4b5a69788796a5b4c3d2e1f0;
  localparam logic [127:0] D4 = 128'hdeadbeef0badf00dcafebabe12345678;
  localparam logic [127:0] D5 = 128'hfedcba98765432100123456789abcdef;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         rs232rx = 1'b1;
  logic [127:0] md5in;
  logic         md5valid;
  logic         frame_err;

  int n_chk = 0;
  int n_pass = 0;
  int fe_count = 0;
  int fe0;
  logic v_pre, v_post, fe_pre, fe_post, fe_post2;

  always #5 clk = ~clk;

  hash_rx #(
    .CLKS_PER_BIT(CPB),
    .TIMEOUT_CLKS(TO)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .rs232rx  (rs232rx),
    .md5in    (md5in),
    .md5valid (md5valid),
    .frame_err(frame_err)
  );

  always @(negedge clk) if (frame_err) fe_count++;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Line falls at edge k; the stop bit is sampled in cycle k+154, so outputs move at edge k+155.
  task automatic send_byte(input logic [7:0] b, input logic stop_lvl);
    rs232rx = 1'b0;
    tick(CPB);
    for (int i = 0; i < 8; i++) begin
      rs232rx = b[i];
      tick(CPB);
    end
    rs232rx = stop_lvl;
    tick(10);
    v_pre  = md5valid;
    fe_pre = frame_err;
    tick(1);
    v_post  = md5valid;
    fe_post = frame_err;
    tick(1);
    fe_post2 = frame_err;
    tick(CPB - 12);
    rs232rx = 1'b1;
  endtask

  task automatic send_digest(input logic [127:0] d, input string tag);
    for (int i = 0; i < 16; i++) send_byte(d[127-8*i -: 8], 1'b1);
    chk({tag, "_valid_before"}, v_pre, 1'b0);
    chk({tag, "_valid_after"}, v_post, 1'b1);
    chk({tag, "_md5in"}, md5in, d);
  endtask

  initial begin
    rst = 1'b1;
    tick(3);
    chk("reset_md5in", md5in, '0);
    chk("reset_valid", md5valid, 1'b0);
    chk("reset_frame_err", frame_err, 1'b0);
    rst = 1'b0;
    tick(5);

    send_digest(D1, "full");

    send_byte(8'h11, 1'b1);
    chk("reload_valid_pre", v_pre, 1'b1);
    chk("reload_valid_drop", v_post, 1'b0);
    chk("reload_md5in_kept", md5in, D1);
    for (int i = 1; i < 16; i++) send_byte(8'(8'h21 + i), 1'b1);
    chk("reload_valid", v_post, 1'b1);
    chk("reload_md5in", md5in, D2);

    for (int i = 0; i < 5; i++) send_byte(8'(8'ha0 + i), 1'b1);
    chk("partial_valid", md5valid, 1'b0);
    tick(TO + 20);
    chk("timeout_valid", md5valid, 1'b0);
    send_digest(D3, "timeout");

    fe0 = fe_count;
    for (int i = 0; i < 3; i++) send_byte(8'(8'h55 + i), 1'b1);
    send_byte(8'h3c, 1'b0);
    chk("ferr_before", fe_pre, 1'b0);
    chk("ferr_pulse", fe_post, 1'b1);
    chk("ferr_after", fe_post2, 1'b0);
    tick(CPB);
    send_digest(D4, "frame");
    chk("ferr_count", 128'(fe_count - fe0), 128'd1);

    fe0 = fe_count;
    rs232rx = 1'b0;
    tick(4);
    rs232rx = 1'b1;
    tick(40);
    chk("glitch_valid", md5valid, 1'b1);
    chk("glitch_no_ferr", 128'(fe_count - fe0), 128'd0);
    send_digest(D5, "glitch");

    send_byte(8'h00, 1'b0);
    chk("ferr_first_pulse", fe_post, 1'b1);
    chk("ferr_first_valid", md5valid, 1'b1);
    chk("ferr_first_md5in", md5in, D5);
    tick(CPB);

    for (int i = 0; i < 7; i++) send_byte(8'(8'hc0 + i), 1'b1);
    rs232rx = 1'b0;
    tick(CPB + CPB / 2 + 3 * CPB);
    rst = 1'b1;
    rs232rx = 1'b1;
    tick(1);
    chk("midrst_md5in", md5in, '0);
    chk("midrst_valid", md5valid, 1'b0);
    chk("midrst_frame_err", frame_err, 1'b0);
    tick(2);
    rst = 1'b0;
    tick(CPB);
    send_digest(D1, "midrst");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #(600_000);
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
